// File: rtl/shift_seq_ctrl.sv
// Iterative barrel shifter: one binary stage (2^k) per clock, SLL/SRL/SRA.
// Define SHIFT_EARLY_DONE_EN to finish once no higher shamt bits remain.
module shift_seq_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  op_i,
  input  logic [31:0] operand_a_i,
  input  logic [4:0]  operand_b_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] result_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] val_q, val_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [1:0]  op_q, op_d;
  logic        sign_q, sign_d;

  logic [7:0]  shamt_ext;
  logic [4:0]  amt;
  logic [31:0] fill_mask;
  logic [31:0] stage_val;
  logic        is_sll;
  logic        is_sra;
  logic        last_stage;

  assign shamt_ext = {3'b000, shamt_q};
  assign amt       = 5'd1 << k_q;
  assign fill_mask = ~(32'hFFFF_FFFF >> amt);
  assign is_sll    = (op_q == 2'b00);
  assign is_sra    = (op_q == 2'b11);

  always_comb begin
    stage_val = val_q;
    if (shamt_ext[k_q]) begin
      unique case (1'b1)
        is_sll:  stage_val = val_q << amt;
        is_sra:  stage_val = (val_q >> amt) | (sign_q ? fill_mask : 32'd0);
        default: stage_val = val_q >> amt;
      endcase
    end
  end

`ifdef SHIFT_EARLY_DONE_EN
  logic [4:0] hi_bits;
  assign hi_bits    = shamt_q >> ({2'b00, k_q} + 5'd1);
  assign last_stage = (k_q == 3'd4) || (hi_bits == 5'd0);
`else
  assign last_stage = (k_q == 3'd4);
`endif

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    val_d    = val_q;
    result_d = result_q;
    shamt_d  = shamt_q;
    op_d     = op_q;
    sign_d   = sign_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          val_d   = operand_a_i;
          shamt_d = operand_b_i;
          op_d    = op_i;
          sign_d  = operand_a_i[31];
          k_d     = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        val_d = stage_val;
        k_d   = k_q + 3'd1;
        if (last_stage) begin
          result_d = stage_val;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      k_q      <= 3'd0;
      val_q    <= 32'd0;
      result_q <= 32'd0;
      shamt_q  <= 5'd0;
      op_q     <= 2'b00;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      val_q    <= val_d;
      result_q <= result_d;
      shamt_q  <= shamt_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign rsp_valid_o = (state_q == DONE);
  assign result_o    = result_q;

endmodule
